// File: rtl/dot_operand_packer_if.sv
// Operand-pair input stream and packed vector-pair output stream of dot_operand_packer.
// The master side is the upstream feeder plus the downstream dot-product unit.
// The slave side is the packer itself.
interface dot_operand_packer_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW*N-1:0] out_vec1;
  logic [DW*N-1:0] out_vec2;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_vec1, out_vec2
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_vec1, out_vec2
  );
endinterface

// File: rtl/dot_operand_packer.sv
// Packs N consecutive (a, b) operand pairs into two DW*N-bit lane vectors for the dot unit.
// Short vectors are closed with in_last; their unused lanes are zero.
// Storage has two stages: an assembly buffer, then the output register.
// Optional macro DOT_PACKER_CNT_EN adds the 16-bit vec_count port.
// vec_count counts vector transfers and wraps from 16'hFFFF to 0.
module dot_operand_packer #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dot_operand_packer_if.slave   bus
`ifdef DOT_PACKER_CNT_EN
  ,
  output logic [15:0]           vec_count
`endif
);

  localparam int unsigned    IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  logic [IdxW-1:0] idx_q, idx_d;
  logic            asm_full_q, asm_full_d;
  logic [DW*N-1:0] asm1_q, asm1_d, asm2_q, asm2_d;
  logic            out_valid_q, out_valid_d;
  logic [DW*N-1:0] out_vec1_q, out_vec1_d, out_vec2_q, out_vec2_d;

  logic accept, complete, slot_free, out_fire;

  assign bus.in_ready  = !asm_full_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec1  = out_vec1_q;
  assign bus.out_vec2  = out_vec2_q;

  assign accept    = bus.in_valid && !asm_full_q;
  assign complete  = accept && ((idx_q == LastIdx) || bus.in_last);
  assign out_fire  = out_valid_q && bus.out_ready;
  assign slot_free = !out_valid_q || bus.out_ready;

  // Assembly buffer: write the accepted pair into lane idx; lane 0 clears the rest for padding.
  always_comb begin
    asm1_d = asm1_q;
    asm2_d = asm2_q;
    idx_d  = idx_q;
    if (accept) begin
      if (idx_q == '0) begin
        asm1_d = '0;
        asm2_d = '0;
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (idx_q == IdxW'(i)) begin
          asm1_d[i*DW +: DW] = bus.in_a;
          asm2_d[i*DW +: DW] = bus.in_b;
        end
      end
      idx_d = complete ? '0 : idx_q + 1'b1;
    end
  end

  // Output register: load a held vector, or load a just-completed vector if the slot frees up.
  always_comb begin
    out_valid_d = out_valid_q;
    out_vec1_d  = out_vec1_q;
    out_vec2_d  = out_vec2_q;
    asm_full_d  = asm_full_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (asm_full_q) begin
      // No accept can happen here, so the assembly buffer is stable.
      if (bus.out_ready) begin
        out_vec1_d  = asm1_q;
        out_vec2_d  = asm2_q;
        out_valid_d = 1'b1;
        asm_full_d  = 1'b0;
      end
    end else if (complete) begin
      if (slot_free) begin
        // asm*_d already holds the element accepted this cycle.
        out_vec1_d  = asm1_d;
        out_vec2_d  = asm2_d;
        out_valid_d = 1'b1;
      end else begin
        asm_full_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      asm_full_q  <= 1'b0;
      asm1_q      <= '0;
      asm2_q      <= '0;
      out_valid_q <= 1'b0;
      out_vec1_q  <= '0;
      out_vec2_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      asm_full_q  <= asm_full_d;
      asm1_q      <= asm1_d;
      asm2_q      <= asm2_d;
      out_valid_q <= out_valid_d;
      out_vec1_q  <= out_vec1_d;
      out_vec2_q  <= out_vec2_d;
    end
  end

`ifdef DOT_PACKER_CNT_EN
  logic [15:0] cnt_q;

  // Transfer counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign vec_count = cnt_q;
`endif

endmodule

// File: tb/tb_dot_operand_packer.sv
// Directed self-checking bench for dot_operand_packer (N=4, DW=8).
// The vec_count wrap check is built only when DOT_PACKER_CNT_EN is defined.
module tb_dot_operand_packer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dot_operand_packer_if #(.N(4), .DW(8)) bus ();

`ifdef DOT_PACKER_CNT_EN
  logic [15:0] vec_count;
  dot_operand_packer #(.N(4), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus), .vec_count(vec_count));
`else
  dot_operand_packer #(.N(4), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_a     = 8'h00;
    bus.in_b     = 8'h00;
    bus.in_last  = 1'b0;
  endtask

  // Drive one pair for a single cycle; in_ready is expected high.
  task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b, input logic last);
    drive(a, b, last);
    chk(tag, 32'(bus.in_ready), 32'd1);
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_vec1", bus.out_vec1, 32'h0);
    chk("rst_vec2", bus.out_vec2, 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    step();

    // Fill and drain
    send("fill_rdy0", 8'd1, 8'd5, 1'b0);
    send("fill_rdy1", 8'd2, 8'd6, 1'b0);
    send("fill_rdy2", 8'd3, 8'd7, 1'b0);
    chk("fill_not_yet", 32'(bus.out_valid), 32'd0);
    send("fill_rdy3", 8'd4, 8'd8, 1'b0);
    idle();
    chk("fill_valid", 32'(bus.out_valid), 32'd1);
    chk("fill_vec1", bus.out_vec1, 32'h04030201);
    chk("fill_vec2", bus.out_vec2, 32'h08070605);
    step();
    chk("fill_one_cycle", 32'(bus.out_valid), 32'd0);

    // Early close
    send("short_rdy0", 8'h09, 8'h03, 1'b0);
    send("short_rdy1", 8'h02, 8'h02, 1'b1);
    idle();
    chk("short_valid", 32'(bus.out_valid), 32'd1);
    chk("short_vec1", bus.out_vec1, 32'h00000209);
    chk("short_vec2", bus.out_vec2, 32'h00000203);
    step();
    chk("short_drained", 32'(bus.out_valid), 32'd0);

    // Full vector after the short one, with idle gaps mid-vector
    send("after_rdy0", 8'h10, 8'h20, 1'b0);
    send("after_rdy1", 8'h11, 8'h21, 1'b0);
    idle();
    step();
    step();
    chk("gap_no_valid", 32'(bus.out_valid), 32'd0);
    send("after_rdy2", 8'h12, 8'h22, 1'b0);
    send("after_rdy3", 8'h13, 8'h23, 1'b0);
    idle();
    chk("after_vec1", bus.out_vec1, 32'h13121110);
    chk("after_vec2", bus.out_vec2, 32'h23222120);
    step();

    // Backpressure
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send("bp_rdy", 8'(k), 8'(k + 128), 1'b0);
      if (k == 4) begin
        chk("bp_v1_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_v1_vec1", bus.out_vec1, 32'h04030201);
      end
    end
    chk("bp_full_rdy", 32'(bus.in_ready), 32'd0);
    drive(8'd9, 8'd137, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stall_rdy", 32'(bus.in_ready), 32'd0);
      chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_stall_vec1", bus.out_vec1, 32'h04030201);
      chk("bp_stall_vec2", bus.out_vec2, 32'h84838281);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_v2_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_v2_vec1", bus.out_vec1, 32'h08070605);
    chk("bp_v2_vec2", bus.out_vec2, 32'h88878685);
    chk("bp_rdy_back", 32'(bus.in_ready), 32'd1);
    step();
    chk("bp_v2_gone", 32'(bus.out_valid), 32'd0);
    send("bp_rdy10", 8'd10, 8'd138, 1'b0);
    send("bp_rdy11", 8'd11, 8'd139, 1'b0);
    send("bp_rdy12", 8'd12, 8'd140, 1'b0);
    idle();
    chk("bp_v3_vec1", bus.out_vec1, 32'h0c0b0a09);
    chk("bp_v3_vec2", bus.out_vec2, 32'h8c8b8a89);
    step();

    // Simultaneous completion and drain
    bus.out_ready = 1'b0;
    send("sim_a0", 8'h31, 8'h41, 1'b0);
    send("sim_a1", 8'h32, 8'h42, 1'b0);
    send("sim_a2", 8'h33, 8'h43, 1'b0);
    send("sim_a3", 8'h34, 8'h44, 1'b0);
    chk("sim_a_vec1", bus.out_vec1, 32'h34333231);
    send("sim_b0", 8'h51, 8'h61, 1'b0);
    send("sim_b1", 8'h52, 8'h62, 1'b0);
    send("sim_b2", 8'h53, 8'h63, 1'b0);
    bus.out_ready = 1'b1;
    send("sim_b3", 8'h54, 8'h64, 1'b0);
    idle();
    chk("sim_b_valid", 32'(bus.out_valid), 32'd1);
    chk("sim_b_vec1", bus.out_vec1, 32'h54535251);
    chk("sim_b_vec2", bus.out_vec2, 32'h64636261);
    chk("sim_b_rdy", 32'(bus.in_ready), 32'd1);
    step();
    chk("sim_b_gone", 32'(bus.out_valid), 32'd0);

    // Reset with a held output and a partial vector
    bus.out_ready = 1'b0;
    send("mr_held", 8'h77, 8'h78, 1'b1);
    send("mr_p0", 8'hAA, 8'hBB, 1'b0);
    send("mr_p1", 8'hCC, 8'hDD, 1'b0);
    idle();
    rst = 1'b1;
    step();
    chk("mr_in_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_in_rst_rdy", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("mr_after_valid", 32'(bus.out_valid), 32'd0);
    send("mr_n0", 8'd1, 8'd1, 1'b0);
    send("mr_n1", 8'd2, 8'd2, 1'b0);
    send("mr_n2", 8'd3, 8'd3, 1'b0);
    chk("mr_not_early", 32'(bus.out_valid), 32'd0);
    send("mr_n3", 8'd4, 8'd4, 1'b0);
    idle();
    chk("mr_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_vec1", bus.out_vec1, 32'h04030201);
    chk("mr_vec2", bus.out_vec2, 32'h04030201);
    step();

`ifdef DOT_PACKER_CNT_EN
    // Counter wrap: 65537 single-element vectors, one per cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt_reset", 32'(vec_count), 32'd0);
    drive(8'h01, 8'h01, 1'b1);
    for (int k = 0; k < 65537; k++) begin
      step();
    end
    idle();
    step();
    chk("cnt_wrap", 32'(vec_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
